sa_feeder: RTL and testbench

Upstream stage of the N×N systolic array: buffers one A/B tile plus bias, then drives the array's `in_a`/`in_b` edges with diagonally skewed, zero-padded streams and a one-cycle `load_bias` pulse. It tells the downstream result consumer when the array's accumulators hold the finished product C = bias + A·B. The array's PE is a registered MAC (1-cycle forward of a/b, accumulate every cycle, `load_bias` overwrites the accumulator with bias).

---
 rtl/sa_pkg.sv | 20 ++
 rtl/sa_tile_buf.sv | 48 ++++
 rtl/sa_feeder.sv | 124 ++++++++++++
 tb/tb_sa_feeder.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
// sa_pkg: shared state type, default dimensions and FEED length for the systolic-array feeder.
package sa_pkg;
    localparam int SA_N          = 4;
    localparam int SA_DATA_WIDTH = 8;
    localparam int SA_ACC_WIDTH  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BIAS,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } sa_feed_state_e;

    // Skewed streams span 3N-2 cycles before PE[N-1][N-1] sees its last operand pair.
    function automatic int feed_len(input int n);
        return 3 * n - 2;
    endfunction
endpackage

// File: rtl/sa_tile_buf.sv
// sa_tile_buf: N-slot buffer of A rows and B columns with a diagonally skewed, zero-padded read port.
module sa_tile_buf
    import sa_pkg::*;
#(
    parameter int N          = SA_N,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int TW         = $clog2(3 * N - 1),
    parameter int SW         = $clog2(N)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [SW-1:0]         i_wr_slot,
    input  logic [DATA_WIDTH-1:0] i_wr_row [N],
    input  logic [DATA_WIDTH-1:0] i_wr_col [N],
    input  logic [TW-1:0]         i_t,
    output logic [DATA_WIDTH-1:0] o_a [N],
    output logic [DATA_WIDTH-1:0] o_b [N]
);
    localparam int KW = TW + 1;

    // r_row[k][m] = A[k][m], r_col[k][m] = B[m][k]; lane g reads element t-g of its own slot.
    logic [DATA_WIDTH-1:0] r_row [N][N];
    logic [DATA_WIDTH-1:0] r_col [N][N];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                for (int m = 0; m < N; m++) begin
                    r_row[k][m] <= '0;
                    r_col[k][m] <= '0;
                end
            end
        end else if (i_wr_en) begin
            r_row[i_wr_slot] <= i_wr_row;
            r_col[i_wr_slot] <= i_wr_col;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [KW-1:0] w_k;
        logic          w_hit;
        assign w_k    = {1'b0, i_t} - KW'(g);
        assign w_hit  = w_k < KW'(N);
        assign o_a[g] = w_hit ? r_row[g][w_k[SW-1:0]] : '0;
        assign o_b[g] = w_hit ? r_col[g][w_k[SW-1:0]] : '0;
    end
endmodule

// File: rtl/sa_feeder.sv
// sa_feeder: loads one A/B tile plus bias, then drives the systolic array's skewed edges
// and flags when the accumulators hold C = bias + A*B.
module sa_feeder
    import sa_pkg::*;
#(
    parameter int N          = SA_N,
    parameter int DATA_WIDTH = SA_DATA_WIDTH,
    parameter int ACC_WIDTH  = SA_ACC_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_a_row [N],
    input  logic [DATA_WIDTH-1:0] s_b_col [N],
    input  logic [ACC_WIDTH-1:0]  s_bias [N],
    output logic                  sa_load_bias,
    output logic [ACC_WIDTH-1:0]  sa_bias [N],
    output logic [DATA_WIDTH-1:0] sa_in_a [N],
    output logic [DATA_WIDTH-1:0] sa_in_b [N],
    output logic                  res_valid,
    input  logic                  res_ack
);
    localparam int FEED_LEN = feed_len(N);
    localparam int TW       = $clog2(3 * N - 1);
    localparam int SW       = $clog2(N);

    sa_feed_state_e        r_state;
    logic [SW-1:0]         r_beat;
    logic [TW-1:0]         r_t;
    logic                  r_load_bias;
    logic                  r_res_valid;
    logic [ACC_WIDTH-1:0]  r_bias [N];
    logic [DATA_WIDTH-1:0] r_in_a [N];
    logic [DATA_WIDTH-1:0] r_in_b [N];
    logic [DATA_WIDTH-1:0] w_rd_a [N];
    logic [DATA_WIDTH-1:0] w_rd_b [N];
    logic [TW-1:0]         w_rd_t;
    logic                  w_accept;
    logic                  w_streaming;

    assign s_ready      = (r_state == ST_IDLE) || (r_state == ST_LOAD);
    assign w_accept     = s_valid && s_ready;
    assign w_streaming  = (r_state == ST_BIAS) || (r_state == ST_FEED);
    // Lanes are registered, so the read port looks one step ahead of the visible t.
    assign w_rd_t       = (r_state == ST_FEED) ? r_t + 1'b1 : '0;
    assign sa_load_bias = r_load_bias;
    assign res_valid    = r_res_valid;
    assign sa_bias      = r_bias;
    assign sa_in_a      = r_in_a;
    assign sa_in_b      = r_in_b;

    sa_tile_buf #(
        .N          (N),
        .DATA_WIDTH (DATA_WIDTH),
        .TW         (TW),
        .SW         (SW)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_accept),
        .i_wr_slot (r_beat),
        .i_wr_row  (s_a_row),
        .i_wr_col  (s_b_col),
        .i_t       (w_rd_t),
        .o_a       (w_rd_a),
        .o_b       (w_rd_b)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_t         <= '0;
            r_load_bias <= 1'b0;
            r_res_valid <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_bias[k] <= '0;
                r_in_a[k] <= '0;
                r_in_b[k] <= '0;
            end
        end else begin
            r_load_bias <= 1'b0;
            for (int k = 0; k < N; k++) begin
                r_in_a[k] <= w_streaming ? w_rd_a[k] : '0;
                r_in_b[k] <= w_streaming ? w_rd_b[k] : '0;
            end
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    if (w_accept) begin
                        if (r_beat == '0) r_bias <= s_bias;
                        if (r_beat == SW'(N - 1)) begin
                            r_beat      <= '0;
                            r_load_bias <= 1'b1;
                            r_state     <= ST_BIAS;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_BIAS: begin
                    r_t     <= '0;
                    r_state <= ST_FEED;
                end
                ST_FEED: begin
                    if (r_t == TW'(FEED_LEN - 1)) r_state <= ST_DRAIN;
                    else r_t <= r_t + 1'b1;
                end
                ST_DRAIN: begin
                    r_res_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ack) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sa_feeder.sv
// tb_sa_feeder: directed tiles through sa_feeder with a behavioural registered-MAC array attached.
module tb_sa_feeder;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 32;

    logic          clk     = 1'b0;
    logic          rst     = 1'b1;
    logic          s_valid = 1'b0;
    logic          res_ack = 1'b0;
    logic          s_ready;
    logic          sa_load_bias;
    logic          res_valid;
    logic [DW-1:0] s_a_row [N];
    logic [DW-1:0] s_b_col [N];
    logic [AW-1:0] s_bias [N];
    logic [AW-1:0] sa_bias [N];
    logic [DW-1:0] sa_in_a [N];
    logic [DW-1:0] sa_in_b [N];

    int          n_pass  = 0;
    int          n_total = 0;
    int          ta [N][N];
    int          tb [N][N];
    int          tbias [N];
    int unsigned acc [N][N];
    int unsigned pa [N][N];
    int unsigned pb [N][N];

    sa_feeder #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a_row      (s_a_row),
        .s_b_col      (s_b_col),
        .s_bias       (s_bias),
        .sa_load_bias (sa_load_bias),
        .sa_bias      (sa_bias),
        .sa_in_a      (sa_in_a),
        .sa_in_b      (sa_in_b),
        .res_valid    (res_valid),
        .res_ack      (res_ack)
    );

    always #5 clk = ~clk;

    // Downstream array: a flows right, b flows down, each PE accumulates every cycle.
    always @(posedge clk) begin
        int unsigned a_in, b_in;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                a_in = (j == 0) ? int'(sa_in_a[i]) : pa[i][j-1];
                b_in = (i == 0) ? int'(sa_in_b[j]) : pb[i-1][j];
                acc[i][j] <= sa_load_bias ? sa_bias[j] : acc[i][j] + a_in * b_in;
                pa[i][j]  <= a_in;
                pb[i][j]  <= b_in;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic logic [31:0] lanes_or();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v |= {24'd0, sa_in_a[i] | sa_in_b[i]};
        return v;
    endfunction

    function automatic logic [31:0] bias_or();
        logic [31:0] v = '0;
        for (int i = 0; i < N; i++) v |= sa_bias[i];
        return v;
    endfunction

    task automatic send_beat(input int k, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        check("beat_ready", s_ready, 1);
        for (int m = 0; m < N; m++) begin
            s_a_row[m] = DW'(ta[k][m]);
            s_b_col[m] = DW'(tb[m][k]);
            s_bias[m]  = (k == 0) ? AW'(tbias[m]) : 32'hdead_beef;
        end
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic run_tile(input int g1, input int g2, input int g3, input bit poke, input bit hand);
        int          lb = 1;
        int          k, ea, eb;
        int unsigned ec;
        int          h3b [N] = '{13, 10, 7, 4};
        send_beat(0, 0);
        send_beat(1, g1);
        send_beat(2, g2);
        send_beat(3, g3);
        check("bias_pulse", sa_load_bias, 1);
        check("bias_lanes_zero", lanes_or(), 0);
        for (int c = 1; c <= 3 * N; c++) begin
            if (poke && c == 4) begin
                s_valid = 1'b1;
                res_ack = 1'b1;
                for (int m = 0; m < N; m++) begin
                    s_a_row[m] = 8'hff;
                    s_b_col[m] = 8'hff;
                end
            end
            @(posedge clk);
            #1;
            s_valid = 1'b0;
            res_ack = 1'b0;
            if (sa_load_bias) lb++;
            check("res_valid", res_valid, 32'(c == 3 * N));
            check("ready_low", s_ready, 0);
            if (c <= 3 * N - 2) begin
                for (int i = 0; i < N; i++) begin
                    k  = c - 1 - i;
                    ea = (k >= 0 && k < N) ? ta[i][k] : 0;
                    eb = (k >= 0 && k < N) ? tb[k][i] : 0;
                    check($sformatf("in_a[%0d] t=%0d", i, c - 1), sa_in_a[i], ea);
                    check($sformatf("in_b[%0d] t=%0d", i, c - 1), sa_in_b[i], eb);
                end
            end else begin
                check("tail_lanes_zero", lanes_or(), 0);
            end
            if (hand && c == 4) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("t3_a[%0d]", i), sa_in_a[i], 0);
                    check($sformatf("t3_b[%0d]", i), sa_in_b[i], h3b[i]);
                end
            end
            if (hand && c == 7) begin
                for (int i = 0; i < N; i++) begin
                    check($sformatf("t6_a[%0d]", i), sa_in_a[i], (i == 3) ? 1 : 0);
                    check($sformatf("t6_b[%0d]", i), sa_in_b[i], (i == 3) ? 16 : 0);
                end
            end
        end
        check("load_bias_once", lb, 1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("sa_bias[%0d]", i), sa_bias[i], tbias[i]);
            for (int j = 0; j < N; j++) begin
                ec = tbias[j];
                for (int m = 0; m < N; m++) ec += ta[i][m] * tb[m][j];
                check($sformatf("C[%0d][%0d]", i, j), acc[i][j], ec);
            end
        end
    endtask

    task automatic ack_tile();
        res_ack = 1'b1;
        @(posedge clk);
        #1;
        res_ack = 1'b0;
        check("ack_valid", res_valid, 0);
        check("ack_ready", s_ready, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_ready"}, s_ready, 1);
        check({tag, "_load_bias"}, sa_load_bias, 0);
        check({tag, "_res_valid"}, res_valid, 0);
        check({tag, "_lanes"}, lanes_or(), 0);
        check({tag, "_bias"}, bias_or(), 0);
    endtask

    initial begin
        for (int m = 0; m < N; m++) begin
            s_a_row[m] = '0;
            s_b_col[m] = '0;
            s_bias[m]  = '0;
        end
        #1 rst = 1'b0;
        #1;
        check_reset_state("rst");
        #20 rst = 1'b1;
        @(posedge clk);
        #1;

        // Identity A, B[m][k] = 4m+k+1, zero bias: C = B.
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                ta[i][m] = (i == m) ? 1 : 0;
                tb[i][m] = 4 * i + m + 1;
            end
            tbias[i] = 0;
        end
        run_tile(0, 0, 0, 1'b0, 1'b1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("hold_valid", res_valid, 1);
            check("hold_ready", s_ready, 0);
        end
        ack_tile();

        // All-ones back-to-back, gapped beats, stray s_valid/res_ack during FEED: C = 104+j.
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                ta[i][m] = 1;
                tb[i][m] = 1;
            end
            tbias[i] = 100 + i;
        end
        run_tile(0, 3, 1, 1'b1, 1'b0);
        ack_tile();

        // Reset at FEED t=5 discards the tile.
        for (int i = 0; i < N; i++) tbias[i] = 7;
        for (int k = 0; k < N; k++) send_beat(k, 0);
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        #2 rst = 1'b0;
        #1;
        check_reset_state("midfeed_rst");
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // Fresh tile after reset: A[i][m] = i+m, B = 2I, bias[j] = 10j.
        for (int i = 0; i < N; i++) begin
            for (int m = 0; m < N; m++) begin
                ta[i][m] = i + m;
                tb[i][m] = (i == m) ? 2 : 0;
            end
            tbias[i] = 10 * i;
        end
        run_tile(1, 0, 2, 1'b0, 1'b0);
        ack_tile();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end
endmodule
